// File: rtl/attack_coprocessor_if.sv
// Bus bundle between the attack coprocessor and its physics/controller neighbours.
interface attack_coprocessor_if;
    logic        enable;
    logic        attack_btn;
    logic [31:0] controller_in;
    logic [31:0] my_position;
    logic [31:0] opp_position;
    logic        damage_clear;
    logic        attack_out;
    logic [31:0] knockback_out;
    logic        freeze_out;
    logic [9:0]  damage;

    modport slave (
        input  enable, attack_btn, controller_in, my_position, opp_position, damage_clear,
        output attack_out, knockback_out, freeze_out, damage
    );

    modport master (
        output enable, attack_btn, controller_in, my_position, opp_position, damage_clear,
        input  attack_out, knockback_out, freeze_out, damage
    );
endinterface

// File: rtl/attack_coprocessor.sv
// Melee attack sequencer: windup/active/stun/recovery phases, hitbox test, knockback and damage.
// Optional macro ATTACK_BUFFER_EN adds a one-deep attack buffer during recovery.
module attack_coprocessor #(
    parameter int unsigned WINDUP_CYCLES   = 4,
    parameter int unsigned ACTIVE_CYCLES   = 3,
    parameter int unsigned STUN_CYCLES     = 8,
    parameter int unsigned COOLDOWN_CYCLES = 6,
    parameter int unsigned HIT_RANGE_X     = 40,
    parameter int unsigned HIT_RANGE_Y     = 30,
    parameter int unsigned BASE_KB         = 256,
    parameter int unsigned KB_SCALE        = 4,
    parameter int unsigned ATTACK_DAMAGE   = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    attack_coprocessor_if.slave  bus
);

    localparam int unsigned MAX_A   = (WINDUP_CYCLES > ACTIVE_CYCLES) ? WINDUP_CYCLES : ACTIVE_CYCLES;
    localparam int unsigned MAX_B   = (STUN_CYCLES > COOLDOWN_CYCLES) ? STUN_CYCLES : COOLDOWN_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned DMG_MAX = 999;
    localparam int unsigned KB_SAT  = 32767;

    localparam logic [CNT_W-1:0] WINDUP_LD = CNT_W'(WINDUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LD = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUN_LD   = CNT_W'(STUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WINDUP, S_ACTIVE, S_STUN, S_RECOVERY
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_facing_right;
    logic              r_btn_q;
    logic [9:0]        r_damage, w_damage_nxt;
    logic              r_attack, w_attack_nxt;
    logic              r_freeze, w_freeze_nxt;
    logic [31:0]       r_kb, w_kb_nxt;

    logic              w_rise;
    logic              w_buf_pending;
    logic              w_hit;
    logic              w_unused;

    assign w_rise   = bus.enable & bus.attack_btn & ~r_btn_q;
    assign w_unused = ^{bus.controller_in[31:16], bus.controller_in[7:0]};

    // Hitbox test on 17-bit signed offsets from attacker to opponent
    logic signed [16:0] w_dx, w_dy;
    logic [16:0]        w_adx, w_ady;
    logic               w_in_range, w_dir_ok;

    assign w_dx       = $signed({1'b0, bus.opp_position[31:16]}) - $signed({1'b0, bus.my_position[31:16]});
    assign w_dy       = $signed({1'b0, bus.opp_position[15:0]})  - $signed({1'b0, bus.my_position[15:0]});
    assign w_adx      = w_dx[16] ? 17'(-w_dx) : 17'(w_dx);
    assign w_ady      = w_dy[16] ? 17'(-w_dy) : 17'(w_dy);
    assign w_in_range = (w_adx <= 17'(HIT_RANGE_X)) && (w_ady <= 17'(HIT_RANGE_Y));
    assign w_dir_ok   = r_facing_right ? !w_dx[16] : (w_dx[16] || (w_dx == '0));
    assign w_hit      = bus.enable && (r_state == S_ACTIVE) && w_in_range && w_dir_ok;

    // Knockback magnitude and post-hit damage, both from pre-hit damage
    logic [31:0] w_mag32;
    logic [15:0] w_mag, w_kb_x, w_kb_y;
    logic [10:0] w_dmg_sum;
    logic [9:0]  w_dmg_hit;

    assign w_mag32   = 32'(BASE_KB) + 32'(r_damage) * 32'(KB_SCALE);
    assign w_mag     = (w_mag32 > 32'(KB_SAT)) ? 16'(KB_SAT) : w_mag32[15:0];
    assign w_kb_x    = r_facing_right ? w_mag : (16'd0 - w_mag);
    assign w_kb_y    = {1'b0, w_mag[15:1]};
    assign w_dmg_sum = 11'(r_damage) + 11'(ATTACK_DAMAGE);
    assign w_dmg_hit = (w_dmg_sum > 11'(DMG_MAX)) ? 10'(DMG_MAX) : w_dmg_sum[9:0];

`ifdef ATTACK_BUFFER_EN
    logic r_buf;

    // One-deep buffer: armed by a rise in recovery, consumed by the following idle cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_buf <= 1'b0;
        end else if (bus.enable) begin
            if ((r_state == S_RECOVERY) && w_rise) begin
                r_buf <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_buf <= 1'b0;
            end
        end
    end

    assign w_buf_pending = r_buf;
`else
    assign w_buf_pending = 1'b0;
`endif

    // Next-state, counter and registered-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_damage_nxt = r_damage;

        if (bus.enable) begin
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_rise || w_buf_pending) begin
                        w_state_nxt = S_WINDUP;
                        w_cnt_nxt   = WINDUP_LD;
                    end
                end
                S_WINDUP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = ACTIVE_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_hit) begin
                        w_state_nxt  = S_STUN;
                        w_cnt_nxt    = STUN_LD;
                        w_damage_nxt = w_dmg_hit;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = S_RECOVERY;
                        w_cnt_nxt   = COOL_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_STUN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_RECOVERY;
                        w_cnt_nxt   = COOL_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                S_RECOVERY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (bus.damage_clear) begin
            w_damage_nxt = '0;
        end

        w_attack_nxt = (w_state_nxt == S_STUN);
        w_freeze_nxt = (w_state_nxt != S_IDLE);
        if (w_hit) begin
            w_kb_nxt = {w_kb_x, w_kb_y};
        end else if (w_state_nxt == S_STUN) begin
            w_kb_nxt = r_kb;
        end else begin
            w_kb_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_damage <= '0;
            r_attack <= 1'b0;
            r_freeze <= 1'b0;
            r_kb     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_damage <= w_damage_nxt;
            r_attack <= w_attack_nxt;
            r_freeze <= w_freeze_nxt;
            r_kb     <= w_kb_nxt;
        end
    end

    // Button sampling and joystick facing (facing only tracks while idle)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_q        <= 1'b0;
            r_facing_right <= 1'b1;
        end else if (bus.enable) begin
            r_btn_q <= bus.attack_btn;
            if (r_state == S_IDLE) begin
                if (bus.controller_in[15:8] >= 8'd144) begin
                    r_facing_right <= 1'b1;
                end else if (bus.controller_in[15:8] <= 8'd111) begin
                    r_facing_right <= 1'b0;
                end
            end
        end
    end

    assign bus.attack_out    = r_attack;
    assign bus.knockback_out = r_kb;
    assign bus.freeze_out    = r_freeze;
    assign bus.damage        = r_damage;

endmodule

// File: tb/tb_attack_coprocessor.sv
// Directed bench for attack_coprocessor: hits, misses, boundaries, saturation, pause, reset, buffering.
module tb_attack_coprocessor;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    attack_coprocessor_if bus_if ();

    attack_coprocessor dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One press, then follow freeze_out until idle; optional 5-cycle pause at loop index pause_at
    task automatic run_attack(input int pause_at, output int fz, output int at,
                              output int first_at, output logic [31:0] kb);
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        fz = 0; at = 0; first_at = -1; kb = '0;
        for (int i = 0; i < 80; i++) begin
            if (i == pause_at)     bus_if.enable = 1'b0;
            if (i == pause_at + 5) bus_if.enable = 1'b1;
            if (!bus_if.freeze_out) break;
            fz++;
            if (bus_if.attack_out) begin
                if (first_at < 0) begin
                    first_at = i;
                    kb = bus_if.knockback_out;
                end
                at++;
            end
            step(1);
        end
        bus_if.enable = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!bus_if.freeze_out) break;
            step(1);
        end
        check(tag, 32'(bus_if.freeze_out), 32'd0);
    endtask

    initial begin
        int fz, at, fa;
        logic [31:0] kb;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_if.enable        = 1'b1;
        bus_if.attack_btn    = 1'b0;
        bus_if.controller_in = 32'h0000_8000;
        bus_if.my_position   = {16'd100, 16'd50};
        bus_if.opp_position  = {16'd130, 16'd60};
        bus_if.damage_clear  = 1'b0;
        step(3);
        check("rst_attack", 32'(bus_if.attack_out), 32'd0);
        check("rst_kb", bus_if.knockback_out, 32'd0);
        check("rst_freeze", 32'(bus_if.freeze_out), 32'd0);
        check("rst_damage", 32'(bus_if.damage), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Right hit from reset facing
        run_attack(1000, fz, at, fa, kb);
        check("right_freeze_len", 32'(fz), 32'd19);
        check("right_attack_len", 32'(at), 32'd8);
        check("right_kb", kb, 32'h0100_0080);
        check("right_damage", 32'(bus_if.damage), 32'd7);
        check("right_kb_after", bus_if.knockback_out, 32'd0);

        // Left hit with damage cleared, then a second left hit using damage 7
        bus_if.controller_in = 32'h0000_3200;
        bus_if.opp_position  = {16'd70, 16'd50};
        bus_if.damage_clear  = 1'b1;
        step(1);
        bus_if.damage_clear  = 1'b0;
        step(1);
        run_attack(1000, fz, at, fa, kb);
        check("left_freeze_len", 32'(fz), 32'd19);
        check("left_attack_len", 32'(at), 32'd8);
        check("left_kb", kb, 32'hFF00_0080);
        check("left_damage", 32'(bus_if.damage), 32'd7);
        run_attack(1000, fz, at, fa, kb);
        check("left2_kb", kb, 32'hFEE4_008E);
        check("left2_damage", 32'(bus_if.damage), 32'd14);

        // Out-of-range miss
        bus_if.opp_position = {16'd200, 16'd50};
        run_attack(1000, fz, at, fa, kb);
        check("miss_freeze_len", 32'(fz), 32'd13);
        check("miss_attack_len", 32'(at), 32'd0);
        check("miss_damage", 32'(bus_if.damage), 32'd14);

        // In range but behind a left-facing attacker
        bus_if.opp_position = {16'd130, 16'd60};
        run_attack(1000, fz, at, fa, kb);
        check("behind_attack_len", 32'(at), 32'd0);
        check("behind_damage", 32'(bus_if.damage), 32'd14);

        // Hitbox edges: exactly on the edge hits, one pixel out misses
        bus_if.controller_in = 32'h0000_C800;
        step(1);
        bus_if.opp_position = {16'd140, 16'd80};
        run_attack(1000, fz, at, fa, kb);
        check("edge_kb", kb, 32'h0138_009C);
        check("edge_damage", 32'(bus_if.damage), 32'd21);
        bus_if.opp_position = {16'd141, 16'd80};
        run_attack(1000, fz, at, fa, kb);
        check("edge_out_attack_len", 32'(at), 32'd0);

        // Damage accumulation up to saturation
        bus_if.opp_position = {16'd130, 16'd60};
        bus_if.damage_clear = 1'b1;
        step(1);
        bus_if.damage_clear = 1'b0;
        for (int k = 0; k < 142; k++) run_attack(1000, fz, at, fa, kb);
        check("sat_pre_damage", 32'(bus_if.damage), 32'd994);
        run_attack(1000, fz, at, fa, kb);
        check("sat_kb", kb, 32'h1088_0844);
        check("sat_damage", 32'(bus_if.damage), 32'd999);
        run_attack(1000, fz, at, fa, kb);
        check("sat_hold_damage", 32'(bus_if.damage), 32'd999);

        // Clear coinciding with the hit edge: clear wins, knockback from pre-hit damage
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        step(4);
        bus_if.damage_clear = 1'b1;
        step(1);
        bus_if.damage_clear = 1'b0;
        check("clr_hit_damage", 32'(bus_if.damage), 32'd0);
        check("clr_hit_attack", 32'(bus_if.attack_out), 32'd1);
        check("clr_hit_kb", bus_if.knockback_out, 32'h109C_084E);
        wait_idle("clr_hit_idle");

        // Pause of 5 cycles inside windup stretches the attack by 5
        run_attack(1, fz, at, fa, kb);
        check("pause_freeze_len", 32'(fz), 32'd24);
        check("pause_first_attack", 32'(fa), 32'd10);
        check("pause_damage", 32'(bus_if.damage), 32'd7);

        // A rise while disabled is ignored
        bus_if.enable     = 1'b0;
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        step(1);
        bus_if.enable     = 1'b1;
        step(2);
        check("disabled_rise", 32'(bus_if.freeze_out), 32'd0);

        // Reset asserted during stun clears outputs immediately
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        step(6);
        check("stun_before_reset", 32'(bus_if.attack_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_attack", 32'(bus_if.attack_out), 32'd0);
        check("rst_mid_kb", bus_if.knockback_out, 32'd0);
        check("rst_mid_freeze", 32'(bus_if.freeze_out), 32'd0);
        check("rst_mid_damage", 32'(bus_if.damage), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("rst_mid_stays_idle", 32'(bus_if.freeze_out), 32'd0);

        // Press during recovery of a miss
        bus_if.opp_position = {16'd200, 16'd50};
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        step(8);
        bus_if.attack_btn = 1'b1;
        step(1);
        bus_if.attack_btn = 1'b0;
        wait_idle("buf_recovery_end");
        step(1);
`ifdef ATTACK_BUFFER_EN
        check("buf_windup", 32'(bus_if.freeze_out), 32'd1);
`else
        check("buf_windup", 32'(bus_if.freeze_out), 32'd0);
`endif
        wait_idle("buf_final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
